pipe_hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage pipeline. Owns write-enable and bubble control of PC, IF/ID and ID/EX regs.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/hazard_mdu_timer.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// the hard-wired zero register index and the default MDU latency.
package pipe_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } haz_state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         MDU_LAT_DEF = 4;

endpackage

// File: rtl/hazard_mdu_timer.sv
// Countdown for a multi-cycle MDU op holding EX: loads on entry, decrements
// while waiting, holds during an external stall, and flags the release cycle.
module hazard_mdu_timer #(
    parameter int MDU_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic freeze,
    input  logic load,
    input  logic in_wait,
    output logic last
);

    localparam int CW = $clog2(MDU_LAT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!freeze) begin
            if (load) begin
                cnt <= CW'(MDU_LAT - 1);
            end else if (in_wait && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // The wait cycle with cnt==1 is the one that releases the pipe.
    assign last = in_wait && (cnt == CW'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stall,
// taken-branch flush, MDU freeze and external memory-wait stall.
// Optional perf counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEF,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rt,
    input  logic [4:0]        ex_rt,
    input  logic              ex_mem2reg,
    input  logic              ex_regwr,
    input  logic              ex_branch_taken,
    input  logic              ex_mdu_start,
    input  logic              ext_stall,
`ifdef HAZ_PERF_CNT_EN
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt,
`endif
    output logic              pc_wr_en,
    output logic              ifid_wr_en,
    output logic              ifid_flush,
    output logic              idex_wr_en,
    output logic              idex_bubble,
    output logic              mdu_busy,
    output logic              mdu_done
);

    haz_state_e state_q, state_d;
    logic       load_use;
    logic       mdu_load;
    logic       mdu_last;

    assign load_use = ex_mem2reg && ex_regwr && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Branch outranks an MDU start arriving in the same cycle.
    assign mdu_load = (state_q == RUN) && !ext_stall && !ex_branch_taken && ex_mdu_start;

    hazard_mdu_timer #(
        .MDU_LAT (MDU_LAT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .freeze  (ext_stall),
        .load    (mdu_load),
        .in_wait (state_q == MDU_WAIT),
        .last    (mdu_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_wr_en    = 1'b1;
        ifid_wr_en  = 1'b1;
        ifid_flush  = 1'b0;
        idex_wr_en  = 1'b1;
        idex_bubble = 1'b0;
        mdu_busy    = (state_q == MDU_WAIT);
        mdu_done    = 1'b0;

        if (ext_stall) begin
            pc_wr_en   = 1'b0;
            ifid_wr_en = 1'b0;
            idex_wr_en = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (ex_mdu_start) begin
                        pc_wr_en   = 1'b0;
                        ifid_wr_en = 1'b0;
                        idex_wr_en = 1'b0;
                        state_d    = MDU_WAIT;
                    end else if (load_use) begin
                        pc_wr_en    = 1'b0;
                        ifid_wr_en  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    if (mdu_last) begin
                        mdu_done = 1'b1;
                        state_d  = RUN;
                    end else begin
                        pc_wr_en   = 1'b0;
                        ifid_wr_en = 1'b0;
                        idex_wr_en = 1'b0;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (!pc_wr_en && perf_stall_cnt != '1) begin
                perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
            end
            if (ifid_flush && perf_flush_cnt != '1) begin
                perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: single-cycle vector table, hand-written MDU /
// ext_stall / reset sequences, and a randomized run against a cycle model.
module tb_pipe_hazard_ctrl;

  localparam int MDU_LAT = 4;
  localparam int PERF_W  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem2reg, ex_regwr, ex_branch_taken, ex_mdu_start, ext_stall;
  logic       pc_wr_en, ifid_wr_en, ifid_flush, idex_wr_en, idex_bubble, mdu_busy, mdu_done;
`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] perf_stall_cnt, perf_flush_cnt;
`endif

  // Output vector order: pc, ifid, flush, idex, bubble, busy, done.
  logic [6:0] outs;
  assign outs = {pc_wr_en, ifid_wr_en, ifid_flush, idex_wr_en, idex_bubble, mdu_busy, mdu_done};

  int total = 0;
  int bad   = 0;
  logic [6:0] exp_q[$];

  pipe_hazard_ctrl #(
    .MDU_LAT (MDU_LAT),
    .PERF_W  (PERF_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_rt           (ex_rt),
    .ex_mem2reg      (ex_mem2reg),
    .ex_regwr        (ex_regwr),
    .ex_branch_taken (ex_branch_taken),
    .ex_mdu_start    (ex_mdu_start),
    .ext_stall       (ext_stall),
`ifdef HAZ_PERF_CNT_EN
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
`endif
    .pc_wr_en        (pc_wr_en),
    .ifid_wr_en      (ifid_wr_en),
    .ifid_flush      (ifid_flush),
    .idex_wr_en      (idex_wr_en),
    .idex_bubble     (idex_bubble),
    .mdu_busy        (mdu_busy),
    .mdu_done        (mdu_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt, xrt;
    logic       uses, m2r, rw, br, mdu, st;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[11];

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                        input logic [4:0] xrt, input logic m2r, input logic rw,
                        input logic br, input logic mdu, input logic st);
    id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_rt = xrt;
    ex_mem2reg = m2r; ex_regwr = rw; ex_branch_taken = br; ex_mdu_start = mdu; ext_stall = st;
  endtask

  task automatic idle_in();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    total++;
    if (outs !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, outs, exp);
    end
  endtask

  task automatic cyc_check(input string name, input logic [6:0] exp);
    @(negedge clk);
    check(name, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // left: MDU wait cycles still to come (the last of them releases the pipe).
  int left;
  int m_stall, m_flush;

  function automatic logic [6:0] model_out(input int l);
    logic lu, busy;
    lu = ex_mem2reg && ex_regwr && ex_rt != 0 &&
         (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    busy = (l > 0);
    if (ext_stall)          return {5'b00000, busy, 1'b0};
    if (l == 1)             return 7'b1101011;
    if (l > 1)              return 7'b0000010;
    if (ex_branch_taken)    return 7'b1111100;
    if (ex_mdu_start)       return 7'b0000000;
    if (lu)                 return 7'b0001100;
    return 7'b1101000;
  endfunction

  function automatic int model_next(input int l);
    if (rst)                           return 0;
    if (ext_stall)                     return l;
    if (l > 0)                         return l - 1;
    if (!ex_branch_taken && ex_mdu_start) return MDU_LAT - 1;
    return 0;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [6:0] e;
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1101000};
    vecs[1]  = '{5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0001100};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1101000};
    vecs[3]  = '{5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0001100};
    vecs[4]  = '{5'd3, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1101000};
    vecs[5]  = '{5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1101000};
    vecs[6]  = '{5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1101000};
    vecs[7]  = '{5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'b1111100};
    vecs[8]  = '{5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0000000};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'b0000000};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'b1111100};

    do_reset();
    cyc_check("reset", 7'b1101000);

    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].rs, vecs[i].rt, vecs[i].uses, vecs[i].xrt, vecs[i].m2r,
             vecs[i].rw, vecs[i].br, vecs[i].mdu, vecs[i].st);
      cyc_check($sformatf("vec%0d", i), vecs[i].exp);
      idle_in();
      cyc_check($sformatf("vec%0d_after", i), 7'b1101000);
    end

    // MDU op: stall t0..t2, done at t3; a branch during the wait is ignored.
    ex_mdu_start = 1'b1;
    cyc_check("mdu_t0", 7'b0000000);
    ex_mdu_start = 1'b0;
    cyc_check("mdu_t1", 7'b0000010);
    ex_branch_taken = 1'b1;
    cyc_check("mdu_t2", 7'b0000010);
    ex_branch_taken = 1'b0;
    cyc_check("mdu_t3", 7'b1101011);
    cyc_check("mdu_t4", 7'b1101000);

    // ext_stall at t1 for 2 cycles shifts done to t5.
    ex_mdu_start = 1'b1;
    cyc_check("mst_t0", 7'b0000000);
    ex_mdu_start = 1'b0;
    ext_stall = 1'b1;
    cyc_check("mst_t1", 7'b0000010);
    cyc_check("mst_t2", 7'b0000010);
    ext_stall = 1'b0;
    cyc_check("mst_t3", 7'b0000010);
    cyc_check("mst_t4", 7'b0000010);
    cyc_check("mst_t5", 7'b1101011);
    cyc_check("mst_t6", 7'b1101000);

    // ext_stall on the release cycle suppresses done until it drops.
    ex_mdu_start = 1'b1;
    cyc_check("msd_t0", 7'b0000000);
    ex_mdu_start = 1'b0;
    cyc_check("msd_t1", 7'b0000010);
    cyc_check("msd_t2", 7'b0000010);
    ext_stall = 1'b1;
    cyc_check("msd_t3", 7'b0000010);
    ext_stall = 1'b0;
    cyc_check("msd_t4", 7'b1101011);

    // Reset mid-wait returns to RUN with no done.
    ex_mdu_start = 1'b1;
    cyc_check("mrst_t0", 7'b0000000);
    ex_mdu_start = 1'b0;
    cyc_check("mrst_t1", 7'b0000010);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc_check("mrst_t3", 7'b1101000);
    cyc_check("mrst_t4", 7'b1101000);

`ifdef HAZ_PERF_CNT_EN
    do_reset();
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    idle_in();
    total++;
    if (perf_stall_cnt !== 4'd15) begin
      bad++;
      $display("FAIL perf_sat: got %0d want 15", perf_stall_cnt);
    end
    total++;
    if (perf_flush_cnt !== 4'd0) begin
      bad++;
      $display("FAIL perf_flush0: got %0d want 0", perf_flush_cnt);
    end
`endif

    // Randomized run against the model.
    do_reset();
    left = 0;
    m_stall = 0;
    m_flush = 0;
    for (int c = 0; c < 3000; c++) begin
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_mem2reg      = 1'($urandom_range(0, 1));
      ex_regwr        = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      ex_mdu_start    = ($urandom_range(0, 7) == 0);
      ext_stall       = ($urandom_range(0, 9) == 0);
      rst             = ($urandom_range(0, 99) == 0);
      exp_q.push_back(model_out(left));
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("rand%0d", c), e);
      if (rst) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (!e[6] && m_stall < 15) m_stall++;
        if (e[4] && m_flush < 15) m_flush++;
      end
      left = model_next(left);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    idle_in();

`ifdef HAZ_PERF_CNT_EN
    total++;
    if (perf_stall_cnt !== 4'(m_stall)) begin
      bad++;
      $display("FAIL perf_stall_rand: got %0d want %0d", perf_stall_cnt, m_stall);
    end
    total++;
    if (perf_flush_cnt !== 4'(m_flush)) begin
      bad++;
      $display("FAIL perf_flush_rand: got %0d want %0d", perf_flush_cnt, m_flush);
    end
`endif

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
